decode_queue_stage: RTL and testbench

- Registered instruction-decode stage for the B32P CPU pipeline, placed between fetch and register-read/execute.
- Buffers fetched instructions and their PCs in a QUEUE_DEPTH-entry FIFO.
- Decodes the FIFO head into a registered field bundle, with valid/ready handshakes on both sides and a pipeline flush.
- Generalises the combinational field decode: datapath width and queue depth are parameters; it adds buffering, back-pressure and flush.

---
 rtl/decode_queue_stage.sv | 218 +++++++++++++++++++++
 tb/tb_decode_queue_stage.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_queue_stage.sv
// B32P decode stage: FIFO-buffered instruction queue feeding a
// registered field decoder with valid/ready on both sides and flush.
//
// Ports:
//   clk, reset (async, active-low), flush (sync discard)
//   in_valid/in_ready/in_instr/in_pc     : fetch side
//   out_valid/out_ready/out_pc + fields  : downstream side
//   count                                : FIFO occupancy (excl. output reg)
module decode_queue_stage #(
  parameter int DATA_WIDTH  = 32,
  parameter int QUEUE_DEPTH = 4,
  parameter int PC_WIDTH    = 27
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  in_instr,
  input  logic [PC_WIDTH-1:0]          in_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PC_WIDTH-1:0]          out_pc,
  output logic [3:0]                   instrOP,
  output logic [3:0]                   aluOP,
  output logic [2:0]                   branchOP,
  output logic [DATA_WIDTH-1:0]        constAlu,
  output logic [DATA_WIDTH-1:0]        constAluu,
  output logic [DATA_WIDTH-1:0]        const16,
  output logic [15:0]                  const16u,
  output logic [26:0]                  const27,
  output logic [3:0]                   areg,
  output logic [3:0]                   breg,
  output logic [3:0]                   dreg,
  output logic                         he,
  output logic                         oe,
  output logic                         sig,
  output logic [$clog2(QUEUE_DEPTH):0] count
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;
  localparam int XW = DATA_WIDTH - 16;

  logic [31:0]         mem_instr_q [QUEUE_DEPTH];
  logic [PC_WIDTH-1:0] mem_pc_q    [QUEUE_DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          en_q;

  logic                  out_valid_q, out_valid_d;
  logic [PC_WIDTH-1:0]   out_pc_q, out_pc_d;
  logic [3:0]            instr_op_q, instr_op_d;
  logic [3:0]            alu_op_q, alu_op_d;
  logic [2:0]            branch_op_q, branch_op_d;
  logic [DATA_WIDTH-1:0] const_alu_q, const_alu_d;
  logic [DATA_WIDTH-1:0] const_aluu_q, const_aluu_d;
  logic [DATA_WIDTH-1:0] const16_q, const16_d;
  logic [15:0]           const16u_q, const16u_d;
  logic [26:0]           const27_q, const27_d;
  logic [3:0]            areg_q, areg_d;
  logic [3:0]            breg_q, breg_d;
  logic [3:0]            dreg_q, dreg_d;
  logic                  he_q, he_d;
  logic                  oe_q, oe_d;
  logic                  sig_q, sig_d;

  logic                push;
  logic                pop;
  logic                fifo_empty;
  logic                load_en;
  logic                ld_fifo;
  logic                ld_byp;
  logic                wr_en;
  logic [31:0]         src_instr;
  logic [PC_WIDTH-1:0] src_pc;
  logic                arithc;

  // en_q keeps in_ready low until the first edge after reset release
  assign in_ready   = en_q && (count_q < CW'(QUEUE_DEPTH)) && !flush;
  assign push       = in_valid && in_ready;
  assign pop        = out_valid_q && out_ready;
  assign fifo_empty = (count_q == '0);
  assign load_en    = !out_valid_q || pop;
  assign ld_fifo    = load_en && !fifo_empty;
  // empty FIFO: the incoming word skips the queue
  assign ld_byp     = load_en && fifo_empty && push;
  assign wr_en      = push && !ld_byp;

  assign src_instr = ld_fifo ? mem_instr_q[rd_ptr_q] : in_instr;
  assign src_pc    = ld_fifo ? mem_pc_q[rd_ptr_q] : in_pc;
  assign arithc    = (src_instr[31:28] == 4'b0001);

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    out_valid_d  = out_valid_q;
    out_pc_d     = out_pc_q;
    instr_op_d   = instr_op_q;
    alu_op_d     = alu_op_q;
    branch_op_d  = branch_op_q;
    const_alu_d  = const_alu_q;
    const_aluu_d = const_aluu_q;
    const16_d    = const16_q;
    const16u_d   = const16u_q;
    const27_d    = const27_q;
    areg_d       = areg_q;
    breg_d       = breg_q;
    dreg_d       = dreg_q;
    he_d         = he_q;
    oe_d         = oe_q;
    sig_d        = sig_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      out_valid_d = 1'b0;
    end else begin
      if (wr_en)   wr_ptr_d = wr_ptr_q + 1'b1;
      if (ld_fifo) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(wr_en) - CW'(ld_fifo);
      if (load_en) out_valid_d = ld_fifo || ld_byp;
      if (ld_fifo || ld_byp) begin
        out_pc_d     = src_pc;
        instr_op_d   = src_instr[31:28];
        alu_op_d     = src_instr[27:24];
        branch_op_d  = src_instr[3:1];
        const_alu_d  = {{XW{src_instr[23]}}, src_instr[23:8]};
        const_aluu_d = {{XW{1'b0}}, src_instr[23:8]};
        const16_d    = {{XW{src_instr[27]}}, src_instr[27:12]};
        const16u_d   = src_instr[27:12];
        const27_d    = src_instr[27:1];
        areg_d       = arithc ? src_instr[7:4] : src_instr[11:8];
        breg_d       = arithc ? 4'd0 : src_instr[7:4];
        dreg_d       = src_instr[3:0];
        he_d         = src_instr[8];
        oe_d         = src_instr[0];
        sig_d        = src_instr[0];
      end
    end
  end

  // storage needs no reset; count/pointers gate every read
  always_ff @(posedge clk) begin
    if (wr_en && !flush) begin
      mem_instr_q[wr_ptr_q] <= in_instr;
      mem_pc_q[wr_ptr_q]    <= in_pc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_q         <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      out_valid_q  <= 1'b0;
      out_pc_q     <= '0;
      instr_op_q   <= '0;
      alu_op_q     <= '0;
      branch_op_q  <= '0;
      const_alu_q  <= '0;
      const_aluu_q <= '0;
      const16_q    <= '0;
      const16u_q   <= '0;
      const27_q    <= '0;
      areg_q       <= '0;
      breg_q       <= '0;
      dreg_q       <= '0;
      he_q         <= 1'b0;
      oe_q         <= 1'b0;
      sig_q        <= 1'b0;
    end else begin
      en_q         <= 1'b1;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      out_valid_q  <= out_valid_d;
      out_pc_q     <= out_pc_d;
      instr_op_q   <= instr_op_d;
      alu_op_q     <= alu_op_d;
      branch_op_q  <= branch_op_d;
      const_alu_q  <= const_alu_d;
      const_aluu_q <= const_aluu_d;
      const16_q    <= const16_d;
      const16u_q   <= const16u_d;
      const27_q    <= const27_d;
      areg_q       <= areg_d;
      breg_q       <= breg_d;
      dreg_q       <= dreg_d;
      he_q         <= he_d;
      oe_q         <= oe_d;
      sig_q        <= sig_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_pc    = out_pc_q;
  assign instrOP   = instr_op_q;
  assign aluOP     = alu_op_q;
  assign branchOP  = branch_op_q;
  assign constAlu  = const_alu_q;
  assign constAluu = const_aluu_q;
  assign const16   = const16_q;
  assign const16u  = const16u_q;
  assign const27   = const27_q;
  assign areg      = areg_q;
  assign breg      = breg_q;
  assign dreg      = dreg_q;
  assign he        = he_q;
  assign oe        = oe_q;
  assign sig       = sig_q;
  assign count     = count_q;

endmodule

// File: tb/tb_decode_queue_stage.sv
// Directed bench for decode_queue_stage: 32-bit and 64-bit instances,
// each scenario a task with inline expected-value comparisons.
module tb_decode_queue_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [26:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [26:0] out_pc;
  logic [3:0]  instrOP, aluOP, areg, breg, dreg;
  logic [2:0]  branchOP;
  logic [31:0] constAlu, constAluu, const16;
  logic [15:0] const16u;
  logic [26:0] const27;
  logic        he, oe, sig;
  logic [2:0]  count;

  logic        w_in_valid = 1'b0;
  logic        w_in_ready;
  logic [31:0] w_in_instr = '0;
  logic [26:0] w_in_pc = '0;
  logic        w_out_valid;
  logic        w_out_ready = 1'b1;
  logic [26:0] w_out_pc;
  logic [3:0]  w_instrOP, w_aluOP, w_areg, w_breg, w_dreg;
  logic [2:0]  w_branchOP;
  logic [63:0] w_constAlu, w_constAluu, w_const16;
  logic [15:0] w_const16u;
  logic [26:0] w_const27;
  logic        w_he, w_oe, w_sig;
  logic [2:0]  w_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  decode_queue_stage #(.DATA_WIDTH(32), .QUEUE_DEPTH(4), .PC_WIDTH(27)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .instrOP(instrOP), .aluOP(aluOP), .branchOP(branchOP),
    .constAlu(constAlu), .constAluu(constAluu),
    .const16(const16), .const16u(const16u), .const27(const27),
    .areg(areg), .breg(breg), .dreg(dreg),
    .he(he), .oe(oe), .sig(sig), .count(count)
  );

  decode_queue_stage #(.DATA_WIDTH(64), .QUEUE_DEPTH(4), .PC_WIDTH(27)) dut64 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_instr(w_in_instr), .in_pc(w_in_pc),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_pc(w_out_pc),
    .instrOP(w_instrOP), .aluOP(w_aluOP), .branchOP(w_branchOP),
    .constAlu(w_constAlu), .constAluu(w_constAluu),
    .const16(w_const16), .const16u(w_const16u), .const27(w_const27),
    .areg(w_areg), .breg(w_breg), .dreg(w_dreg),
    .he(w_he), .oe(w_oe), .sig(w_sig), .count(w_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #2;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++; $display("FAIL rst_valid got %b want 0", out_valid);
    end
    n_checks++;
    if (count !== 3'd0) begin
      n_errors++; $display("FAIL rst_count got %0d want 0", count);
    end
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_errors++; $display("FAIL rst_in_ready got %b want 0", in_ready);
    end
    n_checks++;
    if ({out_pc, instrOP, constAlu, dreg} !== '0) begin
      n_errors++; $display("FAIL rst_fields got %h/%h/%h want 0",
                           out_pc, instrOP, constAlu);
    end
    step();
    step();
    reset = 1'b1;
    step();
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++; $display("FAIL post_rst_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_arithc();
    in_valid = 1'b1; in_instr = 32'h1A5F_F203; in_pc = 27'h100;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 27'h100) begin
      n_errors++; $display("FAIL arithc_valid got %b/%h want 1/100",
                           out_valid, out_pc);
    end
    n_checks++;
    if ({instrOP, aluOP, areg, breg, dreg} !== {4'h1, 4'hA, 4'h0, 4'h0, 4'h3})
    begin
      n_errors++; $display("FAIL arithc_regs got %h %h %h %h %h want 1 a 0 0 3",
                           instrOP, aluOP, areg, breg, dreg);
    end
    n_checks++;
    if (constAlu !== 32'h0000_5FF2 || constAluu !== 32'h0000_5FF2) begin
      n_errors++; $display("FAIL arithc_constalu got %h/%h want 00005ff2",
                           constAlu, constAluu);
    end
    n_checks++;
    if (const16 !== 32'hFFFF_A5FF || const16u !== 16'hA5FF) begin
      n_errors++; $display("FAIL arithc_const16 got %h/%h want ffffa5ff/a5ff",
                           const16, const16u);
    end
    n_checks++;
    if (const27 !== 27'h52F_F901) begin
      n_errors++; $display("FAIL arithc_const27 got %h want 52ff901", const27);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++; $display("FAIL arithc_drain got %b want 0", out_valid);
    end
  endtask

  task automatic test_reg_fields();
    in_valid = 1'b1; in_instr = 32'h3000_0A75; in_pc = 27'h104;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    n_checks++;
    if ({areg, breg, dreg} !== {4'hA, 4'h7, 4'h5}) begin
      n_errors++; $display("FAIL reg_abd got %h %h %h want a 7 5",
                           areg, breg, dreg);
    end
    n_checks++;
    if ({he, oe, sig, branchOP, instrOP} !== {1'b0, 1'b1, 1'b1, 3'd2, 4'd3})
    begin
      n_errors++; $display("FAIL reg_flags got he%b oe%b sig%b br%0d op%0d",
                           he, oe, sig, branchOP, instrOP);
    end
    n_checks++;
    if (constAlu !== 32'h0000_000A || const16 !== 32'h0 || out_pc !== 27'h104)
    begin
      n_errors++; $display("FAIL reg_consts got %h %h %h want a 0 104",
                           constAlu, const16, out_pc);
    end
    step();
  endtask

  task automatic test_backpressure();
    logic [31:0] w;
    int acc;
    acc = 0;
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1;
      in_instr = 32'h2100_0000 + acc * 32'h0001_0010;
      in_pc = 27'h200 + 27'(acc);
      #1;
      if (in_ready) acc++;
      step();
    end
    in_valid = 1'b1;
    #1;
    n_checks++;
    if (acc !== 5) begin
      n_errors++; $display("FAIL bp_accepted got %0d want 5", acc);
    end
    n_checks++;
    if (count !== 3'd4 || in_ready !== 1'b0) begin
      n_errors++; $display("FAIL bp_full got count %0d rdy %b want 4 0",
                           count, in_ready);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      w = 32'h2100_0000 + j * 32'h0001_0010;
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== 27'h200 + 27'(j) ||
          const27 !== w[27:1] || dreg !== w[3:0] || areg !== w[11:8]) begin
        n_errors++; $display("FAIL bp_order%0d got v%b pc %h c27 %h want pc %h c27 %h",
                             j, out_valid, out_pc, const27, 27'h200 + 27'(j), w[27:1]);
      end
      step();
    end
    n_checks++;
    if (out_valid !== 1'b0 || count !== 3'd0) begin
      n_errors++; $display("FAIL bp_empty got v%b count %0d want 0 0",
                           out_valid, count);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_instr = 32'h4000_0000 + 32'(k);
      in_pc = 27'h300 + 27'(k);
      step();
    end
    n_checks++;
    if (count !== 3'd4) begin
      n_errors++; $display("FAIL b2b_fill got %0d want 4", count);
    end
    in_instr = 32'h4000_0005; in_pc = 27'h305;
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_errors++; $display("FAIL b2b_full_rdy got %b want 0", in_ready);
    end
    step();
    n_checks++;
    if (count !== 3'd3 || out_pc !== 27'h301) begin
      n_errors++; $display("FAIL b2b_pop got count %0d pc %h want 3 301",
                           count, out_pc);
    end
    step();
    in_valid = 1'b0;
    n_checks++;
    if (count !== 3'd3 || out_pc !== 27'h302) begin
      n_errors++; $display("FAIL b2b_pushpop got count %0d pc %h want 3 302",
                           count, out_pc);
    end
    for (int j = 2; j < 6; j++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== 27'h300 + 27'(j) ||
          dreg !== 4'(j)) begin
        n_errors++; $display("FAIL b2b_order%0d got v%b pc %h d %h want pc %h",
                             j, out_valid, out_pc, dreg, 27'h300 + 27'(j));
      end
      step();
    end
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++; $display("FAIL b2b_dup got v%b pc %h want 0", out_valid, out_pc);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_instr = 32'h5000_0000 + 32'(k);
      in_pc = 27'h400 + 27'(k);
      step();
    end
    n_checks++;
    if (count !== 3'd3) begin
      n_errors++; $display("FAIL fl_fill got %0d want 3", count);
    end
    flush = 1'b1;
    in_instr = 32'h5000_00EE; in_pc = 27'h4EE;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_errors++; $display("FAIL fl_rdy got %b want 0", in_ready);
    end
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || count !== 3'd0) begin
      n_errors++; $display("FAIL fl_clear got v%b count %0d want 0 0",
                           out_valid, count);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_errors++; $display("FAIL fl_ghost%0d got v%b pc %h want 0",
                             k, out_valid, out_pc);
      end
      step();
    end
    in_valid = 1'b1; in_instr = 32'h5000_0009; in_pc = 27'h409;
    step();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 27'h409 || dreg !== 4'h9) begin
      n_errors++; $display("FAIL fl_after got v%b pc %h want 1 409",
                           out_valid, out_pc);
    end
    step();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_instr = 32'h6000_0000 + 32'(k);
      in_pc = 27'h500 + 27'(k);
      step();
    end
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || count !== 3'd0 || in_ready !== 1'b0) begin
      n_errors++; $display("FAIL mrst_ctrl got v%b count %0d rdy %b want 0 0 0",
                           out_valid, count, in_ready);
    end
    n_checks++;
    if ({out_pc, instrOP, const27} !== '0) begin
      n_errors++; $display("FAIL mrst_fields got %h %h %h want 0",
                           out_pc, instrOP, const27);
    end
    step();
    reset = 1'b1;
    step();
    in_valid = 1'b1; in_instr = 32'h6000_0007; in_pc = 27'h507;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 27'h507 || instrOP !== 4'h6) begin
      n_errors++; $display("FAIL mrst_after got v%b pc %h op %h want 1 507 6",
                           out_valid, out_pc, instrOP);
    end
    step();
  endtask

  task automatic test_wide();
    w_in_valid = 1'b1; w_in_instr = 32'h0080_0000; w_in_pc = 27'h600;
    step();
    w_in_valid = 1'b0;
    n_checks++;
    if (w_out_valid !== 1'b1 || w_constAlu !== 64'hFFFF_FFFF_FFFF_8000) begin
      n_errors++; $display("FAIL wide_sext got v%b %h want 1 ffffffffffff8000",
                           w_out_valid, w_constAlu);
    end
    n_checks++;
    if (w_constAluu !== 64'h8000 || w_const16 !== 64'h0800) begin
      n_errors++; $display("FAIL wide_zext got %h %h want 8000 0800",
                           w_constAluu, w_const16);
    end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_arithc();
    test_reg_fields();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_wide();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
